rgb_pwm_drv: RTL and testbench
==============================

RGB_PWM_DRV -- requirements
Module: rgb_pwm_drv

Interface
- REQ-001 SHALL have parameter WIDTH, default 15; bit width of the duty inputs and the period counter.
- REQ-002 SHALL have parameter PERIOD, default 20000; clocks per PWM period; legal range 2 .. 2^WIDTH.
- REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
- REQ-005 SHALL have port en, input, 1: run request.
- REQ-006 SHALL have ports red, green, blue, input, WIDTH each: requested duty in clocks high per period; these are the brightness outputs of the colour-pattern generator.
- REQ-007 SHALL have ports led_r, led_g, led_b, output, 1 each: registered, active-high LED drive.
- REQ-008 SHALL have port period_start, output, 1: registered one-cycle pulse marking counter value 0 of each new period.
- REQ-009 SHALL have port busy, output, 1: high while the state is not S_IDLE.

Function
- REQ-010 SHALL implement states S_IDLE, S_RUN and S_DRAIN, with any illegal encoding recovering to S_IDLE on the next clock.
- REQ-011 In S_IDLE: cnt held at 0; led_* low; period_start low; red/green/blue ignored.
- REQ-012 In S_IDLE with en=1: shadow_r/g/b capture red/green/blue; cnt<=0; period_start<=1; next state S_RUN.
- REQ-013 In S_RUN/S_DRAIN: cnt increments by 1 per clock and wraps from PERIOD-1 to 0.
- REQ-014 Shadow registers SHALL update only on the wrap clock (cnt==PERIOD-1) and the S_IDLE->S_RUN transition; input changes mid-period SHALL NOT alter the current period.
- REQ-015 In S_RUN/S_DRAIN: led_x <= (cnt < shadow_x), with the compare unsigned at WIDTH bits; led_x lags cnt by exactly one clock.
- REQ-016 Duty 0 SHALL give a constantly low output; duty >= PERIOD SHALL give a constantly high output (clamp, no wrap).
- REQ-017 S_RUN, wrap clock, en=1: new shadows are loaded; period_start<=1; state stays S_RUN.
- REQ-018 S_RUN, en=0, not the wrap clock: next state S_DRAIN, and the current period completes with unchanged shadows.
- REQ-019 S_RUN or S_DRAIN, wrap clock, en=0: next state S_IDLE; cnt<=0; led_* <= 0; no period_start pulse; shadows not loaded.
- REQ-020 S_DRAIN, en=1 before the wrap clock: return to S_RUN with cnt continuing, not reset.
- REQ-021 Simultaneous en change and input change SHALL resolve per REQ-012..REQ-020; inputs matter only on load clocks.
- REQ-022 period_start SHALL be high for exactly one clock per started period and never in S_IDLE.

Reset
- REQ-023 rst_n=0 at a clock edge: state<=S_IDLE; cnt<=0; shadows<=0; led_r/g/b, period_start and busy <=0.
- REQ-024 Reset mid-period SHALL take effect on that edge regardless of state, with no drain.
- REQ-025 Initial register values SHALL equal the reset values.

Structure
- REQ-026 State encodings and the default WIDTH/PERIOD constants SHALL reside in the shared light-show constants package.
- REQ-027 The per-channel compare-and-register SHALL be one sub-module, pwm_chan, instantiated three times; the counter and FSM are in the top level.

Verification (bench PERIOD=20, WIDTH=15)
- REQ-028 Reset then en=1 with red=5, green=0, blue=20: per period led_r high 5 clocks, led_g never high, led_b always high; period_start every 20 clocks.
- REQ-029 red changed 5->12 at cnt=7: the current period keeps 5 high clocks; the next period has 12.
- REQ-030 en dropped at cnt=3: busy stays high until the wrap; the period completes; then S_IDLE, all led_* low, no further period_start.
- REQ-031 en dropped at cnt=3 and reasserted at cnt=10: no gap; the counter continues; the next period starts at the normal wrap with a period_start pulse.
- REQ-032 rst_n=0 at cnt=9 with led_r high: all outputs 0 on the next edge; release with en=1 restarts with period_start and cnt=0.
- REQ-033 Duties red=19, red=20 and red=32767 give high times of 19, 20 and 20 clocks respectively.

Source files
------------

// File: rtl/rgb_pwm_drv_pkg.sv
// Shared light-show constants: FSM encodings and default PWM geometry.
package rgb_pwm_drv_pkg;

    localparam int DEF_WIDTH  = 15;
    localparam int DEF_PERIOD = 20000;
    localparam int NUM_CHAN   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } state_t;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: duty shadow register plus registered compare against the shared counter.
module pwm_chan #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             run,
    input  logic [WIDTH-1:0] cnt,
    input  logic [WIDTH-1:0] duty,
    output logic             led
);

    logic [WIDTH-1:0] shadow = '0;
    logic             led_q  = 1'b0;

    // Counter never exceeds PERIOD-1, so any duty >= PERIOD naturally stays high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow <= '0;
            led_q  <= 1'b0;
        end else begin
            if (load)
                shadow <= duty;
            led_q <= run ? (cnt < shadow) : 1'b0;
        end
    end

    assign led = led_q;

endmodule

// File: rtl/rgb_pwm_drv.sv
// Three-channel RGB PWM driver: period counter and run/drain FSM feeding three pwm_chan slices.
module rgb_pwm_drv
    import rgb_pwm_drv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] red,
    input  logic [WIDTH-1:0] green,
    input  logic [WIDTH-1:0] blue,
    output logic             led_r,
    output logic             led_g,
    output logic             led_b,
    output logic             period_start,
    output logic             busy
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

    state_t           state    = S_IDLE;
    state_t           state_nxt;
    logic [WIDTH-1:0] cnt      = '0;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ps_q     = 1'b0;
    logic             ps_nxt;
    logic             load;
    logic             run;
    logic             wrap;

    logic [NUM_CHAN-1:0][WIDTH-1:0] duty;
    logic [NUM_CHAN-1:0]            led;

    assign wrap = (cnt == LAST);
    assign duty = {blue, green, red};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            ps_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            ps_q  <= ps_nxt;
        end
    end

    // en only matters at load points: leaving idle, and the wrap clock.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ps_nxt    = 1'b0;
        load      = 1'b0;
        run       = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    load      = 1'b1;
                    ps_nxt    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                cnt_nxt = wrap ? '0 : cnt + WIDTH'(1);
                if (wrap) begin
                    if (en) begin
                        load      = 1'b1;
                        ps_nxt    = 1'b1;
                        run       = 1'b1;
                        state_nxt = S_RUN;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    run       = 1'b1;
                    state_nxt = en ? S_RUN : S_DRAIN;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_CHAN; i++) begin : g_chan
        pwm_chan #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load),
            .run   (run),
            .cnt   (cnt),
            .duty  (duty[i]),
            .led   (led[i])
        );
    end

    assign led_r        = led[0];
    assign led_g        = led[1];
    assign led_b        = led[2];
    assign period_start = ps_q;
    assign busy         = (state != S_IDLE);

endmodule

// File: tb/tb_rgb_pwm_drv.sv
// Scoreboard bench for rgb_pwm_drv: a period-level reference model queues expected outputs per clock.
module tb_rgb_pwm_drv;

    localparam int W = 15;
    localparam int P = 20;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic [W-1:0] red   = '0;
    logic [W-1:0] green = '0;
    logic [W-1:0] blue  = '0;
    logic         led_r, led_g, led_b, period_start, busy;

    rgb_pwm_drv #(.WIDTH(W), .PERIOD(P)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .led_r        (led_r),
        .led_g        (led_g),
        .led_b        (led_b),
        .period_start (period_start),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic busy;
        logic ps;
        logic r;
        logic g;
        logic b;
    } obs_t;

    obs_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_n    = 0;

    // Reference model: a lit period is just "position within period" plus three clamped duties.
    bit   m_active = 1'b0;
    int   m_pos    = 0;
    int   m_duty[3] = '{0, 0, 0};

    function automatic int clampd(input logic [W-1:0] d);
        return (int'(d) >= P) ? P : int'(d);
    endfunction

    task automatic model_step(input logic rs, input logic e,
                              input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b);
        obs_t o = '0;
        int   nd[3];
        nd[0] = clampd(r);
        nd[1] = clampd(g);
        nd[2] = clampd(b);
        if (!rs) begin
            m_active = 1'b0;
            m_pos    = 0;
        end else if (!m_active) begin
            if (e) begin
                m_active = 1'b1;
                m_pos    = 0;
                m_duty   = nd;
                o.ps     = 1'b1;
            end
        end else begin
            o.r = (m_pos < m_duty[0]);
            o.g = (m_pos < m_duty[1]);
            o.b = (m_pos < m_duty[2]);
            if (m_pos == P - 1) begin
                m_pos = 0;
                if (e) begin
                    m_duty = nd;
                    o.ps   = 1'b1;
                end else begin
                    m_active = 1'b0;
                    o.r = 1'b0;
                    o.g = 1'b0;
                    o.b = 1'b0;
                end
            end else begin
                m_pos++;
            end
        end
        o.busy = m_active;
        exp_q.push_back(o);
    endtask

    task automatic cyc(input logic rs, input logic e,
                       input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b);
        rst_n = rs;
        en    = e;
        red   = r;
        green = g;
        blue  = b;
        @(posedge clk);
        model_step(rs, e, r, g, b);
        @(negedge clk);
    endtask

    task automatic run_n(input int n, input logic e,
                         input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b);
        for (int k = 0; k < n; k++)
            cyc(1'b1, e, r, g, b);
    endtask

    task automatic run_to(input int pos, input logic e,
                          input logic [W-1:0] r, input logic [W-1:0] g, input logic [W-1:0] b);
        for (int k = 0; k < 2 * P && m_pos != pos; k++)
            cyc(1'b1, e, r, g, b);
    endtask

    function automatic logic [W-1:0] pick_duty();
        logic [W-1:0] d;
        case ($urandom_range(0, 5))
            0:       d = '0;
            1:       d = W'(P - 1);
            2:       d = W'(P);
            3:       d = W'(P + 1);
            4:       d = W'($urandom_range(1, P - 1));
            default: d = '1;
        endcase
        return d;
    endfunction

    initial begin
        obs_t got;
        obs_t want;
        forever begin
            @(posedge clk);
            #1;
            cyc_n++;
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                got  = {busy, period_start, led_r, led_g, led_b};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL cycle %0d outputs{busy,ps,r,g,b} got=%b want=%b", cyc_n, got, want);
                end
            end
        end
    end

    initial begin
        logic         e;
        logic [W-1:0] r, g, b;
        @(negedge clk);
        repeat (3) cyc(1'b0, 1'b0, '0, '0, '0);

        // start, then red change mid-period
        cyc(1'b1, 1'b1, 15'd5, 15'd0, 15'd20);
        run_n(2 * P, 1'b1, 15'd5, 15'd0, 15'd20);
        run_to(7, 1'b1, 15'd5, 15'd0, 15'd20);
        run_n(2 * P, 1'b1, 15'd12, 15'd0, 15'd20);

        // drain to idle; inputs ignored while idle
        run_to(3, 1'b1, 15'd12, 15'd0, 15'd20);
        run_n(P + 6, 1'b0, 15'd12, 15'd0, 15'd20);
        run_n(5, 1'b0, 15'd7, 15'd9, 15'd3);

        // drop and re-raise en within one period
        cyc(1'b1, 1'b1, 15'd5, 15'd3, 15'd20);
        run_to(3, 1'b1, 15'd5, 15'd3, 15'd20);
        run_to(10, 1'b0, 15'd5, 15'd3, 15'd20);
        run_n(2 * P, 1'b1, 15'd5, 15'd3, 15'd20);

        // reset mid-period with led_r high, then restart
        run_to(9, 1'b1, 15'd12, 15'd0, 15'd20);
        cyc(1'b0, 1'b1, 15'd12, 15'd0, 15'd20);
        cyc(1'b1, 1'b1, 15'd12, 15'd0, 15'd20);
        run_n(P, 1'b1, 15'd12, 15'd0, 15'd20);

        // duty boundaries
        run_n(2 * P, 1'b1, 15'd19, 15'd1, 15'd0);
        run_n(2 * P, 1'b1, 15'd20, 15'd19, 15'd1);
        run_n(2 * P, 1'b1, 15'd32767, 15'd21, 15'd20);

        // randomized traffic
        e = 1'b1;
        r = pick_duty();
        g = pick_duty();
        b = pick_duty();
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 15) == 0) e = ~e;
            if ($urandom_range(0, 7) == 0) r = pick_duty();
            if ($urandom_range(0, 7) == 0) g = pick_duty();
            if ($urandom_range(0, 7) == 0) b = pick_duty();
            cyc(($urandom_range(0, 199) != 0), e, r, g, b);
        end
        run_n(3, 1'b0, '0, '0, '0);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
